// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - handshaked pipeline stage register with one-entry skid buffer
// Registered In_Ready, flush-to-bubble and a saturating stall-cycle counter.
module pipe_skid_stage #(
    parameter int                 DATA_W       = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_VALUE = '0,
    parameter int                 CNT_W        = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  Stall_Count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q;
    logic              in_xfer;
    logic              out_xfer;

    assign Out_Valid   = (state != S_EMPTY);
    assign In_Ready    = in_ready_q;
    assign Out_Data    = main_q;
    assign Occupancy   = state;
    assign Stall_Count = stall_q;

    assign in_xfer  = In_Valid && in_ready_q;
    assign out_xfer = Out_Valid && Out_Ready;

    // main is returned to the bubble whenever the stage drains, so Out_Data never shows stale data
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = S_ONE;
                    main_nxt  = In_Data;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_nxt = In_Data;
                end else if (in_xfer) begin
                    state_nxt = S_TWO;
                    skid_nxt  = In_Data;
                end else if (out_xfer) begin
                    state_nxt = S_EMPTY;
                    main_nxt  = BUBBLE_VALUE;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    state_nxt = S_ONE;
                    main_nxt  = skid_q;
                    skid_nxt  = BUBBLE_VALUE;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
                main_nxt  = BUBBLE_VALUE;
                skid_nxt  = BUBBLE_VALUE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            state      <= S_EMPTY;
            main_q     <= BUBBLE_VALUE;
            skid_q     <= BUBBLE_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != S_TWO);
        end
    end

    // Flush leaves the counter alone; only Reset clears it
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_q <= '0;
        end else if (Out_Valid && !Out_Ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, handshaked pipeline stage register that replaces fixed-width IF/ID-style registers with write-enable and flush.
- Uses valid/ready flow control with a one-entry skid buffer, so upstream ready is a registered signal and throughput stays at full rate under backpressure.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...). Flush converts all held entries into bubbles.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (for example instruction[31:0] plus PC+4[31:0]).
- BUBBLE_VALUE, 0, value driven on Out_Data after reset or flush (0 = NOP encoding).
- CNT_W, 16, width of the stall counter.

Ports:
- Clock  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous, active-high; discards all held entries.
- In_Valid  input  1  upstream has data on In_Data.
- In_Ready  output  1  stage can accept data this cycle; driven from a register.
- In_Data  input  DATA_W  upstream payload.
- Out_Valid  output  1  Out_Data holds a valid entry.
- Out_Ready  input  1  downstream accepts Out_Data this cycle.
- Out_Data  output  DATA_W  head entry payload.
- Occupancy  output  2  number of entries held: 0, 1 or 2.
- Stall_Count  output  CNT_W  cycles in which Out_Valid=1 and Out_Ready=0.

Behaviour:
- Storage: a main register (drives Out_Data) plus a skid register.
- States: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
- Handshakes:
  - Input transfer occurs when In_Valid && In_Ready.
  - Output transfer occurs when Out_Valid && Out_Ready.
- Output signals:
  - Out_Valid = (state != EMPTY).
  - In_Ready = (state != TWO), registered, no combinational path from Out_Ready.
  - Occupancy encodes the state directly.
- Transitions, applied when Reset=0 and Flush=0:
  - EMPTY, input transfer -> ONE; main <= In_Data.
  - ONE, input only -> TWO; skid <= In_Data.
  - ONE, output only -> EMPTY.
  - ONE, both -> ONE; main <= In_Data.
  - ONE, neither -> hold.
  - TWO, output transfer -> ONE; main <= skid. In_Ready is 0, so no input transfer occurs in TWO.
  - TWO, no output -> hold.
- Latency and throughput:
  - 1 cycle from input transfer to Out_Valid when the stage is empty.
  - Sustains 1 transfer per cycle when Out_Ready is held at 1.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Out_Data when Out_Valid=0 is BUBBLE_VALUE, never stale data.
- Reset=1: state <= EMPTY, main and skid <= BUBBLE_VALUE, Stall_Count <= 0.
  - Takes effect at the next rising edge, mid-operation included.
  - After that edge: In_Ready=1, Out_Valid=0, Occupancy=0.
- Flush=1: same effect as Reset on state, main and skid. Stall_Count is not cleared.
  - Any In_Data presented in the same cycle is discarded, even if In_Valid && In_Ready.
- Priority: Reset > Flush > handshake logic.
- Stall_Count:
  - Increments at each edge where Out_Valid=1 and Out_Ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by Reset.
- Out_Ready is ignored while Out_Valid=0.
- In_Data is ignored while In_Ready=0.

Test Plan:
- Reset, then stream 0x11, 0x22, 0x33 with In_Valid=1 and Out_Ready=1 -> Out_Data shows 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after each transfer. Occupancy stays ≤1 and Stall_Count=0.
- Send 0xA then 0xB with Out_Ready=0 -> Occupancy goes 1 then 2, In_Ready=0 after the second edge, Out_Data=0xA. Raise Out_Ready for 2 cycles -> 0xA then 0xB, Occupancy 0, Stall_Count equals the number of held cycles.
- State TWO (0xA, 0xB), assert Flush with In_Valid=1 and In_Data=0xC -> next cycle Occupancy=0, Out_Valid=0, Out_Data=BUBBLE_VALUE, In_Ready=1, 0xC never appears, Stall_Count retained.
- Assert Reset mid-stream with Occupancy=2 and Stall_Count=5 -> all outputs at reset values and Stall_Count=0 after one edge.
- CNT_W=4, hold Out_Valid=1 and Out_Ready=0 for 20 cycles -> Stall_Count saturates at 15 and stays there.
- Randomised valid/ready for 10k cycles with scoreboard -> output sequence equals input sequence, no loss or duplication, In_Ready never 1 while Occupancy=2.
